// File: rtl/adder_bist_checker_pkg.sv
// Shared definitions for the adder BIST checker: FSM state encoding and
// default operand width / settle time.
package adder_bist_checker_pkg;

  localparam int DEF_WIDTH  = 1;
  localparam int DEF_SETTLE = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adder_bist_checker_if.sv
// Operand/result bus between the BIST checker (master) and the adder under
// test (slave).
interface adder_bist_checker_if #(
  parameter int WIDTH = adder_bist_checker_pkg::DEF_WIDTH
);

  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic [WIDTH-1:0] dut_s;
  logic             dut_c;

  modport master (
    output dut_a,
    output dut_b,
    input  dut_s,
    input  dut_c
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    output dut_s,
    output dut_c
  );

endinterface

// File: rtl/adder_bist_checker_golden.sv
// Combinational reference adder: full-width {carry,sum} of two WIDTH-bit
// operands, used as the golden result for each test vector.
module adder_bist_checker_golden #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  // Widen both operands so the carry is never truncated.
  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_bist_checker.sv
// Built-in self-test for an adder: sweeps every operand pair, holds each for
// SETTLE cycles, compares the adder's {carry,sum} with a golden sum and
// reports pass/fail, error count and the first failing operands.
// Optional build macro BIST_STOP_ON_FAIL_EN: end the run at the first mismatch.
module adder_bist_checker
  import adder_bist_checker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  adder_bist_checker_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2*WIDTH:0]      err_count,
  output logic [WIDTH-1:0]      fail_a,
  output logic [WIDTH-1:0]      fail_b
);

  localparam int VW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

  state_t           state, state_nxt;
  logic [VW-1:0]    vec, vec_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [EW-1:0]    err_nxt;
  logic [WIDTH-1:0] fail_a_nxt, fail_b_nxt;

  logic [WIDTH:0]   expected;
  logic             mismatch;
  logic [EW-1:0]    err_upd;
  logic             vec_last;

  // Operands come straight from the vector register.
  assign bus.dut_a = vec[WIDTH-1:0];
  assign bus.dut_b = vec[VW-1:WIDTH];

  adder_bist_checker_golden #(.WIDTH(WIDTH)) u_golden (
    .a   (bus.dut_a),
    .b   (bus.dut_b),
    .sum (expected)
  );

  assign mismatch = ({bus.dut_c, bus.dut_s} != expected);
  assign err_upd  = mismatch ? (err_count + EW'(1)) : err_count;
  assign vec_last = &vec;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_nxt  = state;
    vec_nxt    = vec;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    done_nxt   = done;
    pass_nxt   = pass;
    err_nxt    = err_count;
    fail_a_nxt = fail_a;
    fail_b_nxt = fail_b;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_nxt    = '0;
          err_nxt    = '0;
          fail_a_nxt = '0;
          fail_b_nxt = '0;
          done_nxt   = 1'b0;
          pass_nxt   = 1'b0;
          busy_nxt   = 1'b1;
          cnt_nxt    = SETTLE_LD;
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        err_nxt = err_upd;
        if (mismatch && (err_count == '0)) begin
          fail_a_nxt = bus.dut_a;
          fail_b_nxt = bus.dut_b;
        end
`ifdef BIST_STOP_ON_FAIL_EN
        if (mismatch || vec_last) begin
          state_nxt = ST_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_upd == '0);
        end else begin
          vec_nxt   = vec + VW'(1);
          cnt_nxt   = SETTLE_LD;
          state_nxt = ST_WAIT;
        end
`else
        if (vec_last) begin
          state_nxt = ST_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_upd == '0);
        end else begin
          vec_nxt   = vec + VW'(1);
          cnt_nxt   = SETTLE_LD;
          state_nxt = ST_WAIT;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and result registers; reset clears every partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      cnt       <= cnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
      fail_a    <= fail_a_nxt;
      fail_b    <= fail_b_nxt;
    end
  end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: a fault-injectable adder model (per-vector XOR
// masks on {carry,sum}) and a sweep-level reference model of the expected
// run results.
module tb_adder_bist_checker;

  localparam int W  = 1;
  localparam int S  = 2;
  localparam int NV = 1 << (2 * W);

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           busy;
  logic           done;
  logic           pass;
  logic [2*W:0]   err_count;
  logic [W-1:0]   fail_a;
  logic [W-1:0]   fail_b;

  logic [W:0]     mask [NV];

  int checks = 0;
  int errors = 0;

  adder_bist_checker_if #(.WIDTH(W)) bus ();

  adder_bist_checker #(.WIDTH(W), .SETTLE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b)
  );

  // Adder under test: correct sum with a per-vector fault mask applied.
  assign {bus.dut_c, bus.dut_s} =
    ({1'b0, bus.dut_a} + {1'b0, bus.dut_b}) ^ mask[{bus.dut_b, bus.dut_a}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err"}, 32'(err_count), 0);
    check({tag, "_fail_a"}, 32'(fail_a), 0);
    check({tag, "_fail_b"}, 32'(fail_b), 0);
    check({tag, "_dut_a"}, 32'(bus.dut_a), 0);
    check({tag, "_dut_b"}, 32'(bus.dut_b), 0);
  endtask

  // Run one full test and compare against the expected sweep outcome.
  task automatic run(input string tag, input int repulse_at);
    int  n;
    bit  busy_ok;
    int  n_err;
    int  first;
    int  exp_edges;
    int  exp_err;
    int  exp_vec;
    int  exp_fa;
    int  exp_fb;
    int  good;
    int  got;
    // Reference: walk every (a,b) pair in sweep order.
    n_err = 0;
    first = -1;
    for (int v = 0; v < NV; v++) begin
      int a;
      int b;
      a    = v % (1 << W);
      b    = v / (1 << W);
      good = a + b;
      got  = good ^ int'(mask[v]);
      if (got != good) begin
        n_err++;
        if (first < 0) first = v;
      end
    end
`ifdef BIST_STOP_ON_FAIL_EN
    exp_edges = (first >= 0) ? (first + 1) * (S + 1) : NV * (S + 1);
    exp_err   = (first >= 0) ? 1 : 0;
    exp_vec   = (first >= 0) ? first : NV - 1;
`else
    exp_edges = NV * (S + 1);
    exp_err   = n_err;
    exp_vec   = NV - 1;
`endif
    exp_fa = (first >= 0) ? first % (1 << W) : 0;
    exp_fb = (first >= 0) ? first / (1 << W) : 0;

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 1);
    check({tag, "_done_after_start"}, 32'(done), 0);

    n = 0;
    busy_ok = 1'b1;
    while (n < 200) begin
      if (n == repulse_at) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_done_edge"}, 32'(n), 32'(exp_edges));
    check({tag, "_busy_held"}, 32'(busy_ok), 1);
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
    check({tag, "_fail_a"}, 32'(fail_a), 32'(exp_fa));
    check({tag, "_fail_b"}, 32'(fail_b), 32'(exp_fb));
    check({tag, "_dut_a"}, 32'(bus.dut_a), 32'(exp_vec % (1 << W)));
    check({tag, "_dut_b"}, 32'(bus.dut_b), 32'(exp_vec / (1 << W)));
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_hold"}, 32'(done), 1);
    check({tag, "_err_hold"}, 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int v = 0; v < NV; v++) mask[v] = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_no_start_busy", 32'(busy), 0);

    // Correct adder.
    run("good", -1);

    // Carry stuck at 0: only 1+1 produces a carry.
    for (int v = 0; v < NV; v++) mask[v] = '0;
    mask[NV-1] = 2'b10;
    run("stuck_carry", -1);

    // Inverted sum bit on every vector.
    for (int v = 0; v < NV; v++) mask[v] = 2'b01;
    run("inv_sum", -1);

    // Start re-pulsed mid-run is ignored.
    for (int v = 0; v < NV; v++) mask[v] = '0;
    mask[2] = 2'b11;
    run("repulse", 5);

    // Back-to-back run from DONE with a clean adder.
    for (int v = 0; v < NV; v++) mask[v] = '0;
    run("restart", -1);

    // Reset mid-run at cycle 7.
    mask[1] = 2'b01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_run_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(busy), 0);
    run("post_reset", -1);

    // Randomised fault patterns.
    for (int r = 0; r < 8; r++) begin
      for (int v = 0; v < NV; v++) begin
        mask[v] = ($urandom % 2 == 0) ? '0 : (W+1)'($urandom_range(1, 3));
      end
      run($sformatf("rand%0d", r), ($urandom % 3 == 0) ? int'($urandom_range(1, 10)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
